// File: rtl/logic_unit_pkg.sv
// -----------------------------------------------------------------------------
// logic_unit_pkg
// Shared definitions for the bitwise logic unit and its built-in self-test:
//   - opcode encodings (OP_AND .. OP_BUF)
//   - per-opcode 4-bit truth tables, indexed by {a_i, b_i}
//   - BIST sequencer state encoding
// -----------------------------------------------------------------------------
package logic_unit_pkg;

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_NAND = 3'd2;
   localparam logic [2:0] OP_NOR  = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_XNOR = 3'd5;
   localparam logic [2:0] OP_NOT  = 3'd6;
   localparam logic [2:0] OP_BUF  = 3'd7;

   // Bit k of a table is the gate output for {a_i, b_i} == k.
   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_XNOR = 4'b1001;
   localparam logic [3:0] TT_NOT  = 4'b0011;
   localparam logic [3:0] TT_BUF  = 4'b1100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } bist_state_t;

   // Reference truth table for an opcode; deliberately independent of the
   // operator-based gate mux in logic_gate_core.
   function automatic logic [3:0] tt_lookup(input logic [2:0] op);
      case (op)
         OP_AND:  return TT_AND;
         OP_OR:   return TT_OR;
         OP_NAND: return TT_NAND;
         OP_NOR:  return TT_NOR;
         OP_XOR:  return TT_XOR;
         OP_XNOR: return TT_XNOR;
         OP_NOT:  return TT_NOT;
         default: return TT_BUF;
      endcase
   endfunction

endpackage

// File: rtl/logic_gate_core.sv
// -----------------------------------------------------------------------------
// logic_gate_core
// Purely combinational bitwise gate: y = f_op(a, b) over WIDTH bits.
// Ports:
//   op  [2:0]        gate select (see logic_unit_pkg opcodes)
//   a   [WIDTH-1:0]  operand A
//   b   [WIDTH-1:0]  operand B (ignored for NOT a / BUF a)
//   y   [WIDTH-1:0]  result
// -----------------------------------------------------------------------------
module logic_gate_core
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      // NOTE: a default assignment before the case keeps every path driven,
      // so no latch is inferred even if the case is later edited.
      y = '0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_XOR:  y = a ^ b;
         OP_XNOR: y = ~(a ^ b);
         OP_NOT:  y = ~a;
         OP_BUF:  y = a;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/logic_unit_bist.sv
// -----------------------------------------------------------------------------
// logic_unit_bist
// Registered two-operand bitwise logic unit with a valid/ready stream and a
// built-in self-test that sweeps every {op, a, b} through the same datapath
// and compares against a truth-table reference model.
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   in_valid / in_ready      operand beat handshake
//   op, a, b                 operands
//   out_valid / out_ready    result handshake
//   y                        registered result
//   bist_start               self-test request pulse
//   bist_inject              inverts y[0] into the comparator (fault injection)
//   bist_busy / bist_done    self-test running / finished (sticky)
//   bist_pass                done with zero mismatches
//   err_count                saturating mismatch count of the last self-test
// -----------------------------------------------------------------------------
module logic_unit_bist
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   input  logic             bist_start,
   input  logic             bist_inject,
   output logic             bist_busy,
   output logic             bist_done,
   output logic             bist_pass,
   output logic [ERR_W-1:0] err_count
);

   localparam int VEC_W = 3 + 2 * WIDTH;

   bist_state_t      state;
   logic             pending;
   logic [VEC_W-1:0] vec;
   logic [WIDTH-1:0] exp_q;
   logic             chk_valid;

   logic             go;
   logic             accept;
   logic             running;
   logic [2:0]       vec_op;
   logic [WIDTH-1:0] vec_a;
   logic [WIDTH-1:0] vec_b;
   logic [2:0]       core_op;
   logic [WIDTH-1:0] core_a;
   logic [WIDTH-1:0] core_b;
   logic [WIDTH-1:0] core_y;
   logic [3:0]       ref_tt;
   logic [WIDTH-1:0] ref_y;
   logic [WIDTH-1:0] obs_y;
   logic             mismatch;

   // Self-test entry: a request is pending and no functional result is left.
   assign go = (state == ST_IDLE) & pending & ~out_valid;

   // Also closed on the entry cycle so no beat slips in as the sweep takes
   // over the output register.
   assign in_ready = ~bist_busy & ~go & (~out_valid | out_ready);
   assign accept   = in_valid & in_ready;
   assign running  = (state == ST_RUN);

   assign vec_op = vec[VEC_W-1 -: 3];
   assign vec_a  = vec[2*WIDTH-1 -: WIDTH];
   assign vec_b  = vec[WIDTH-1:0];

   assign core_op = running ? vec_op : op;
   assign core_a  = running ? vec_a  : a;
   assign core_b  = running ? vec_b  : b;

   logic_gate_core #(.WIDTH(WIDTH)) u_core (
      .op (core_op),
      .a  (core_a),
      .b  (core_b),
      .y  (core_y)
   );

   // Reference model: per-bit truth-table lookup on the issued vector.
   always_comb begin
      ref_tt = tt_lookup(vec_op);
      ref_y  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         ref_y[i] = ref_tt[{vec_a[i], vec_b[i]}];
      end
   end

   always_comb begin
      obs_y    = y;
      obs_y[0] = y[0] ^ bist_inject;
   end

   assign mismatch = chk_valid & (obs_y != exp_q);

   // Output register, shared by the functional path and the self-test sweep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: state is updated with non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         y         <= '0;
         out_valid <= 1'b0;
      end else if (running) begin
         y <= core_y;
      end else if (accept) begin
         y         <= core_y;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Self-test sequencer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         pending   <= 1'b0;
         vec       <= '0;
         exp_q     <= '0;
         chk_valid <= 1'b0;
         bist_busy <= 1'b0;
         bist_done <= 1'b0;
         bist_pass <= 1'b0;
         err_count <= '0;
      end else begin
         chk_valid <= 1'b0;
         if (mismatch && (err_count != {ERR_W{1'b1}})) begin
            err_count <= err_count + 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (bist_start) pending <= 1'b1;
               if (go) begin
                  pending   <= 1'b0;
                  bist_done <= 1'b0;
                  bist_pass <= 1'b0;
                  err_count <= '0;
                  bist_busy <= 1'b1;
                  vec       <= '0;
                  state     <= ST_RUN;
               end
            end
            ST_RUN: begin
               // Expected value travels one cycle behind its vector, in step
               // with the registered result it is compared against.
               exp_q     <= ref_y;
               chk_valid <= 1'b1;
               vec       <= vec + 1'b1;
               if (vec == {VEC_W{1'b1}}) state <= ST_FLUSH;
            end
            ST_FLUSH: begin
               bist_busy <= 1'b0;
               state     <= ST_DONE;
            end
            default: begin
               bist_done <= 1'b1;
               bist_pass <= (err_count == '0);
               if (bist_start) pending <= 1'b1;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/logic_unit_bist.md
Name: logic_unit_bist

Overview:
- Parametrised, registered two-operand bitwise logic unit: eight selectable gate functions with a valid/ready stream interface.
- Carries a built-in self-test (BIST) sequencer that sweeps every opcode and operand combination through the same datapath.
- BIST checks each result against an independent truth-table model and counts mismatches.
- Successor to the team's single-gate blocks; used as the shared gate primitive with on-chip self-check.

Parameters:
- WIDTH, 4, operand and result width in bits (1..8; the BIST sweep grows as 2^(2*WIDTH)).
- ERR_W, 8, width of the saturating BIST error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit accepts a beat.
- op  input  3  0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 BUF a.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; ignored for op 6 and 7.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- y  output  WIDTH  result.
- bist_start  input  1  self-test request; single-cycle pulse.
- bist_inject  input  1  while high during BIST, inverts y[0] into the comparator (fault injection).
- bist_busy  output  1  self-test running.
- bist_done  output  1  self-test finished; sticky.
- bist_pass  output  1  bist_done and err_count==0.
- err_count  output  ERR_W  mismatch count from the last self-test.

Behaviour:
- Reset: in_ready=1, out_valid=0, y=0, bist_busy=0, bist_done=0, bist_pass=0, err_count=0, pending-start flag=0, FSM=IDLE.
- Functional path:
  - Single output register; latency 1 cycle from accepted beat to out_valid.
  - in_ready = ~bist_busy & (~out_valid | out_ready). A beat is accepted when in_valid & in_ready.
  - Simultaneous accept and drain: the new result replaces the old; out_valid stays 1.
  - While out_valid=1 and out_ready=0, y is held stable.
- Gate evaluation is bitwise over WIDTH. The unit only ever produces WIDTH-bit results.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE: a bist_start pulse sets the pending flag. Move to RUN when pending=1 and out_valid=0 (any functional result is drained first). On entry: clear pending, bist_done, and err_count; set bist_busy=1.
  - RUN: a vector counter {op, a, b} of 3+2*WIDTH bits starts at 0 and increments each cycle. The vector drives the datapath internally; external in_valid is ignored and out_valid is forced 0. The expected result is registered alongside.
    - Comparison happens one cycle after issue.
    - When the counter reaches its all-ones value, move to FLUSH.
  - FLUSH: compare the last vector, then move to DONE.
  - DONE: bist_busy=0, bist_done=1, and bist_pass is set from err_count. Return to IDLE in the same cycle; bist_done and bist_pass remain sticky until the next BIST entry.
- Timing: N = 8*2^(2*WIDTH) vectors. bist_busy is high for exactly N+1 cycles.
- Reference model: per-op 4-bit truth-table constant indexed by {a_i, b_i}, evaluated per bit. It must not share logic with the datapath gate mux.
- err_count increments by 1 per mismatching vector (any bit differs) and saturates at 2^ERR_W-1.
- bist_start while busy: ignored; no pending flag is set.
- Reset mid-BIST: all state returns to reset values immediately; no partial result is retained.

Decomposition:
- Shared package logic_unit_pkg:
  - opcode constants OP_AND..OP_BUF;
  - per-op truth-table constants (4 bits each);
  - FSM state encodings.
- Sub-module logic_gate_core: purely combinational op/a/b -> y. Instantiated once in the datapath; the reference model stays separate, in the checker.

Test Plan:
- WIDTH=4; op=2, a=4'b1100, b=4'b1010 -> y=4'b0111 with out_valid=1 one cycle after accept. Repeat for ops 0,1,3,4,5 -> 1000, 1110, 0001, 0110, 1001.
- out_ready=0 with a result held, then a second beat offered -> in_ready=0 and y stable. Raise out_ready while in_valid=1 -> back-to-back accept, out_valid stays 1, new y next cycle.
- WIDTH=2, ERR_W=8; pulse bist_start, inject=0 -> bist_busy high 129 cycles, then bist_done=1, bist_pass=1, err_count=0. in_ready=0 and out_valid=0 throughout.
- WIDTH=2; BIST with bist_inject=1 throughout -> err_count=128, bist_pass=0.
- WIDTH=4, ERR_W=8; BIST with inject=1 -> err_count saturates at 255.
- bist_start while out_valid=1 and out_ready=0 -> BIST deferred until drained. Assert rst_n=0 mid-RUN -> all outputs at reset values. A new bist_start afterwards completes normally.
